// File: rtl/nice_gemm_pkg.sv
// Shared NICE GEMM encoding: instruction fields, funct7 map, FSM states and descriptor layout.
// Used by both the host-side issuer and the accelerator decode.
package nice_gemm_pkg;

    localparam logic [6:0] NICE_OPCODE   = 7'b0101011;
    localparam logic [2:0] NICE_FUNCT3   = 3'b011;

    localparam logic [6:0] CFG_ROWS      = 7'b0000001;
    localparam logic [6:0] CFG_COLS_BIAS = 7'b0000010;
    localparam logic [6:0] CFG_ADDR      = 7'b0000100;
    localparam logic [6:0] CFG_OFFS      = 7'b0001000;
    localparam logic [6:0] CFG_ACT       = 7'b0010000;
    localparam logic [6:0] CFG_QUANT     = 7'b0100000;
    localparam logic [6:0] START         = 7'b1000000;

    localparam int         NUM_CFG       = 6;
    localparam logic [2:0] START_IDX     = 3'd6;

    localparam int STAT_CFG_ERR   = 0;
    localparam int STAT_CFG_NAK   = 1;
    localparam int STAT_MULTI_ERR = 2;
    localparam int STAT_TIMEOUT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_MC,
        ST_DONE
    } issuer_state_e;

    typedef struct packed {
        logic [31:0] rhs_rows;
        logic [31:0] lhs_rows;
        logic [31:0] rhs_cols;
        logic [31:0] bias_addr;
        logic [31:0] lhs_addr;
        logic [31:0] rhs_addr;
        logic [31:0] lhs_offset;
        logic [31:0] dst_offset;
        logic [31:0] act_min;
        logic [31:0] act_max;
        logic [31:0] dst_multi_addr;
        logic [31:0] dst_shifts_addr;
        logic [31:0] dst_addr;
    } gemm_desc_t;

    function automatic logic [31:0] build_instr(input logic [6:0] funct7);
        return {funct7, 10'b0, NICE_FUNCT3, 5'b0, NICE_OPCODE};
    endfunction

    function automatic logic [6:0] idx_funct7(input logic [2:0] idx);
        logic [6:0] f;
        case (idx)
            3'd0:    f = CFG_ROWS;
            3'd1:    f = CFG_COLS_BIAS;
            3'd2:    f = CFG_ADDR;
            3'd3:    f = CFG_OFFS;
            3'd4:    f = CFG_ACT;
            3'd5:    f = CFG_QUANT;
            default: f = START;
        endcase
        return f;
    endfunction

    // Lowest set mask bit at or above 'from'; START_IDX when none is left.
    function automatic logic [2:0] next_idx(input logic [5:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = START_IDX;
        for (int i = NUM_CFG - 1; i >= 0; i--)
            if (mask[i] && (3'(i) >= from)) r = 3'(i);
        return r;
    endfunction

    // {rs1, rs2} for a given instruction index.
    function automatic logic [63:0] operands(input gemm_desc_t d, input logic [2:0] idx);
        logic [63:0] r;
        case (idx)
            3'd0:    r = {d.rhs_rows,       d.lhs_rows};
            3'd1:    r = {d.rhs_cols,       d.bias_addr};
            3'd2:    r = {d.lhs_addr,       d.rhs_addr};
            3'd3:    r = {d.lhs_offset,     d.dst_offset};
            3'd4:    r = {d.act_min,        d.act_max};
            3'd5:    r = {d.dst_multi_addr, d.dst_shifts_addr};
            default: r = {d.dst_addr,       32'h0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nice_gemm_issuer_if.sv
// NICE request/response channel between the issuer (master) and the GEMM accelerator (slave).
interface nice_gemm_issuer_if;
    logic        nice_req_valid;
    logic        nice_req_ready;
    logic [31:0] nice_req_instr;
    logic [31:0] nice_req_rs1;
    logic [31:0] nice_req_rs2;
    logic [31:0] nice_req_rs1_1;
    logic [31:0] nice_req_rs2_1;
    logic        nice_req_mmode;
    logic        nice_rsp_1cyc_type;
    logic        nice_rsp_1cyc_err;
    logic [31:0] nice_rsp_1cyc_dat;
    logic [31:0] nice_rsp_1cyc_dat_1;
    logic        nice_rsp_multicyc_valid;
    logic        nice_rsp_multicyc_ready;
    logic [31:0] nice_rsp_multicyc_dat;
    logic        nice_rsp_multicyc_err;

    modport master (
        output nice_req_valid, nice_req_instr, nice_req_rs1, nice_req_rs2,
               nice_req_rs1_1, nice_req_rs2_1, nice_req_mmode, nice_rsp_multicyc_ready,
        input  nice_req_ready, nice_rsp_1cyc_type, nice_rsp_1cyc_err, nice_rsp_1cyc_dat,
               nice_rsp_1cyc_dat_1, nice_rsp_multicyc_valid, nice_rsp_multicyc_dat,
               nice_rsp_multicyc_err
    );

    modport slave (
        input  nice_req_valid, nice_req_instr, nice_req_rs1, nice_req_rs2,
               nice_req_rs1_1, nice_req_rs2_1, nice_req_mmode, nice_rsp_multicyc_ready,
        output nice_req_ready, nice_rsp_1cyc_type, nice_rsp_1cyc_err, nice_rsp_1cyc_dat,
               nice_rsp_1cyc_dat_1, nice_rsp_multicyc_valid, nice_rsp_multicyc_dat,
               nice_rsp_multicyc_err
    );
endinterface

// File: rtl/nice_gemm_issuer.sv
// Issues the masked GEMM config instructions plus START over NICE, then waits for completion.
// Reports done pulse and sticky {timeout, multi_err, cfg_nak, cfg_err} status.
module nice_gemm_issuer
    import nice_gemm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                      nice_clk,
    input  logic                      nice_rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [5:0]                cmd_cfg_mask,
    input  logic [31:0]               cmd_rhs_rows,
    input  logic [31:0]               cmd_lhs_rows,
    input  logic [31:0]               cmd_rhs_cols,
    input  logic [31:0]               cmd_bias_addr,
    input  logic [31:0]               cmd_lhs_addr,
    input  logic [31:0]               cmd_rhs_addr,
    input  logic [31:0]               cmd_lhs_offset,
    input  logic [31:0]               cmd_dst_offset,
    input  logic [31:0]               cmd_act_min,
    input  logic [31:0]               cmd_act_max,
    input  logic [31:0]               cmd_dst_multi_addr,
    input  logic [31:0]               cmd_dst_shifts_addr,
    input  logic [31:0]               cmd_dst_addr,
    nice_gemm_issuer_if.master        nice,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                status
);

    // A zero timeout still needs a 1-bit counter; it simply never expires.
    localparam int unsigned     CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    issuer_state_e    state_q, state_d;
    logic [2:0]       idx_q;
    logic [5:0]       mask_q;
    gemm_desc_t       desc_q, desc_in;
    logic [CNT_W-1:0] cnt_q;

    logic       accept, req_hs, mc_hs, expired;
    logic [2:0] idx_first, idx_nxt;

    assign desc_in = '{
        rhs_rows:        cmd_rhs_rows,
        lhs_rows:        cmd_lhs_rows,
        rhs_cols:        cmd_rhs_cols,
        bias_addr:       cmd_bias_addr,
        lhs_addr:        cmd_lhs_addr,
        rhs_addr:        cmd_rhs_addr,
        lhs_offset:      cmd_lhs_offset,
        dst_offset:      cmd_dst_offset,
        act_min:         cmd_act_min,
        act_max:         cmd_act_max,
        dst_multi_addr:  cmd_dst_multi_addr,
        dst_shifts_addr: cmd_dst_shifts_addr,
        dst_addr:        cmd_dst_addr
    };

    assign accept    = cmd_valid & cmd_ready;
    assign req_hs    = nice.nice_req_valid & nice.nice_req_ready;
    assign mc_hs     = nice.nice_rsp_multicyc_valid & nice.nice_rsp_multicyc_ready;
    assign expired   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX);
    assign idx_first = next_idx(cmd_cfg_mask, 3'd0);
    assign idx_nxt   = next_idx(mask_q, idx_q + 3'd1);

    assign nice.nice_req_rs1_1 = 32'h0;
    assign nice.nice_req_rs2_1 = 32'h0;
    assign nice.nice_req_mmode = 1'b0;

    logic unused_rsp;
    assign unused_rsp = ^{nice.nice_rsp_1cyc_dat, nice.nice_rsp_1cyc_dat_1[31:1],
                          nice.nice_rsp_multicyc_dat};

    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_ISSUE;
            ST_ISSUE:   if (req_hs && idx_q == START_IDX) state_d = ST_WAIT_MC;
            ST_WAIT_MC: if (mc_hs || expired) state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready                    = (state_q == ST_IDLE);
        nice.nice_rsp_multicyc_ready = (state_q == ST_WAIT_MC);
    end

    // Request outputs are preloaded one cycle ahead so each handshake is followed
    // directly by the next instruction.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            idx_q               <= 3'd0;
            mask_q              <= 6'd0;
            desc_q              <= '0;
            cnt_q               <= '0;
            nice.nice_req_valid <= 1'b0;
            nice.nice_req_instr <= 32'h0;
            nice.nice_req_rs1   <= 32'h0;
            nice.nice_req_rs2   <= 32'h0;
            busy                <= 1'b0;
            done                <= 1'b0;
            status              <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    desc_q              <= desc_in;
                    mask_q              <= cmd_cfg_mask;
                    status              <= 4'h0;
                    busy                <= 1'b1;
                    idx_q               <= idx_first;
                    nice.nice_req_valid <= 1'b1;
                    nice.nice_req_instr <= build_instr(idx_funct7(idx_first));
                    {nice.nice_req_rs1, nice.nice_req_rs2} <= operands(desc_in, idx_first);
                end
                ST_ISSUE: if (req_hs) begin
                    if (idx_q != START_IDX) begin
                        status[STAT_CFG_ERR] <= status[STAT_CFG_ERR] | nice.nice_rsp_1cyc_err;
                        status[STAT_CFG_NAK] <= status[STAT_CFG_NAK] | ~nice.nice_rsp_1cyc_type
                                                | ~nice.nice_rsp_1cyc_dat_1[0];
                        idx_q               <= idx_nxt;
                        nice.nice_req_instr <= build_instr(idx_funct7(idx_nxt));
                        {nice.nice_req_rs1, nice.nice_req_rs2} <= operands(desc_q, idx_nxt);
                    end else begin
                        nice.nice_req_valid <= 1'b0;
                        nice.nice_req_instr <= 32'h0;
                        nice.nice_req_rs1   <= 32'h0;
                        nice.nice_req_rs2   <= 32'h0;
                        cnt_q               <= '0;
                    end
                end
                ST_WAIT_MC: begin
                    // Completion handshake takes priority over a same-cycle expiry.
                    if (mc_hs) begin
                        status[STAT_MULTI_ERR] <= nice.nice_rsp_multicyc_err;
                        done                   <= 1'b1;
                        busy                   <= 1'b0;
                    end else if (expired) begin
                        status[STAT_TIMEOUT] <= 1'b1;
                        done                 <= 1'b1;
                        busy                 <= 1'b0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
